// File: rtl/adder_operand_loader_pkg.sv
// Shared encodings for the adder operand loader.
// State codes match the adder datapath/controller.
package adder_operand_loader_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    HOLD    = 2'd2
  } ld_state_e;

endpackage

// File: rtl/adder_hold_timer.sv
// Loadable down-counter that times the post-go hold window.
// done is high while the count sits at 1 (last hold cycle).
module adder_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/adder_operand_loader.sv
// Assembles four nibble beats into A..D, pulses go,
// then blocks input for a fixed hold window.
module adder_operand_loader
  import adder_operand_loader_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = 8,
  parameter int LAST_CHECK  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             go,
  output logic             busy,
  output logic             err_frame,
  output logic [7:0]       sets_issued
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  ld_state_e               state_q;
  ld_state_e               state_d;
  logic                    rdy_q;
  logic [1:0]              beat_q;
  logic [2:0][WIDTH-1:0]   shadow_q;
  logic                    accept;
  logic                    last_beat;
  logic                    frame_bad;
  logic                    commit;
  logic                    hold_done;

  assign in_ready  = rdy_q && (state_q == COLLECT);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_q == 2'd3);
  assign frame_bad = (LAST_CHECK != 0) && (in_last != last_beat);
  assign commit    = accept && last_beat && !frame_bad;

  adder_hold_timer #(
    .W (HW)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == ISSUE),
    .load_val (HW'(HOLD_CYCLES)),
    .done     (hold_done)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and go/busy decode
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (commit) state_d = ISSUE;
      end
      ISSUE: begin
        go      = 1'b1;
        busy    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_done) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // beat capture, atomic commit, framing and set count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q       <= 1'b0;
      beat_q      <= 2'd0;
      shadow_q    <= '0;
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
      err_frame   <= 1'b0;
      sets_issued <= 8'd0;
    end else begin
      rdy_q     <= 1'b1;
      err_frame <= accept && frame_bad;
      if (accept) begin
        if (frame_bad) begin
          beat_q   <= 2'd0;
          shadow_q <= '0;
        end else if (last_beat) begin
          A      <= shadow_q[0];
          B      <= shadow_q[1];
          C      <= shadow_q[2];
          D      <= in_data;
          beat_q <= 2'd0;
        end else begin
          shadow_q[beat_q] <= in_data;
          beat_q           <= beat_q + 2'd1;
        end
      end
      if (state_q == ISSUE) begin
        sets_issued <= sets_issued + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for the adder operand loader.
// Adder sum is modelled as A+B+C+D.
module tb_adder_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] A, B, C, D;
  logic       go, busy, err_frame;
  logic [7:0] sets_issued;

  int         checks = 0;
  int         failures = 0;
  int         go_cnt = 0;
  logic [7:0] exp_sets = 8'd0;
  logic [15:0] held = '0;

  adder_operand_loader #(
    .WIDTH       (4),
    .HOLD_CYCLES (8),
    .LAST_CHECK  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .go          (go),
    .busy        (busy),
    .err_frame   (err_frame),
    .sets_issued (sets_issued)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // go counting, go/err exclusion, operand stability
  always @(negedge clk) begin
    if (rst) begin
      if (go) begin
        go_cnt++;
        held = {A, B, C, D};
        if (err_frame) check("go_err_excl", 32'(err_frame), 32'd0);
      end else if (busy) begin
        check("hold_stable", 32'({A, B, C, D}), 32'(held));
      end
    end
  end

  task automatic send_beat(input logic [3:0] d, input logic last);
    int n;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_set(input logic [3:0] a, b, c, d,
                          input logic [3:0] lastv,
                          input bit exp_go,
                          input string tag);
    send_beat(a, lastv[0]);
    send_beat(b, lastv[1]);
    send_beat(c, lastv[2]);
    send_beat(d, lastv[3]);
    @(negedge clk);
    check({tag, "_go"}, 32'(go), 32'(exp_go));
    if (exp_go) begin
      check({tag, "_ops"}, 32'({A, B, C, D}), 32'({a, b, c, d}));
      check({tag, "_sum"}, 32'(A) + 32'(B) + 32'(C) + 32'(D),
            32'(a) + 32'(b) + 32'(c) + 32'(d));
      exp_sets = exp_sets + 8'd1;
      @(negedge clk);
      check({tag, "_sets"}, 32'(sets_issued), 32'(exp_sets));
    end else begin
      check({tag, "_err"}, 32'(err_frame), 32'd1);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b0;
    exp_sets = 8'd0;
    #1;
    check("rst_outs", 32'({A, B, C, D, go, busy, err_frame, in_ready}), 32'd0);
    check("rst_sets", 32'(sets_issued), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rdy_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst_rdy_up", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int g0;
    repeat (2) @(negedge clk);
    do_reset();

    // 1: basic set
    send_set(4'd1, 4'd2, 4'd3, 4'd4, 4'b1000, 1'b1, "s1");

    // 2: valid held high across the hold window
    send_beat(4'd1, 1'b0);
    send_beat(4'd2, 1'b0);
    send_beat(4'd3, 1'b0);
    send_beat(4'd4, 1'b1);
    @(negedge clk);
    check("s2_go", 32'(go), 32'd1);
    in_data = 4'd5;
    in_last = 1'b0;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
      if (!in_ready) check("s2_ops_held", 32'({A, B, C, D}), 32'h1234);
    end
    check("s2_ready_lat", 32'(n), 32'd9);
    exp_sets = exp_sets + 8'd1;
    check("s2_sets_mid", 32'(sets_issued), 32'(exp_sets));
    send_set(4'd5, 4'd6, 4'd7, 4'd8, 4'b1000, 1'b1, "s2");

    // 3: early in_last
    g0 = go_cnt;
    send_beat(4'd9, 1'b0);
    send_beat(4'd9, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("s3_err", 32'(err_frame), 32'd1);
    check("s3_nogo", 32'(go), 32'd0);
    @(negedge clk);
    check("s3_err_pulse", 32'(err_frame), 32'd0);
    check("s3_ops", 32'({A, B, C, D}), 32'h5678);
    check("s3_gocnt", 32'(go_cnt - g0), 32'd0);
    send_set(4'd10, 4'd11, 4'd12, 4'd13, 4'b1000, 1'b1, "s3b");

    // 4: missing in_last on beat 3
    g0 = go_cnt;
    send_set(4'd1, 4'd1, 4'd1, 4'd1, 4'b0000, 1'b0, "s4");
    in_valid = 1'b0;
    @(negedge clk);
    check("s4_sets", 32'(sets_issued), 32'(exp_sets));
    check("s4_ops", 32'({A, B, C, D}), 32'hABCD);
    check("s4_gocnt", 32'(go_cnt - g0), 32'd0);

    // 5: reset mid-set, then mid-hold
    send_beat(4'd2, 1'b0);
    send_beat(4'd3, 1'b0);
    g0 = go_cnt;
    #2;
    do_reset();
    repeat (2) @(negedge clk);
    check("s5_nogo", 32'(go_cnt - g0), 32'd0);
    send_set(4'd4, 4'd3, 4'd2, 4'd1, 4'b1000, 1'b1, "s5a");
    repeat (2) @(negedge clk);
    check("s5_busy", 32'(busy), 32'd1);
    do_reset();
    send_set(4'd7, 4'd7, 4'd7, 4'd7, 4'b1000, 1'b1, "s5b");

    // 6: 256 sets, counter wraps
    in_valid = 1'b0;
    do_reset();
    g0 = go_cnt;
    for (int i = 0; i < 256; i++) begin
      send_set(4'd15, 4'd15, 4'd15, 4'd15, 4'b1000, 1'b1, "s6");
      if (i == 254) check("s6_255", 32'(sets_issued), 32'd255);
    end
    check("s6_wrap", 32'(sets_issued), 32'd0);
    check("s6_gocnt", 32'(go_cnt - g0), 32'd256);

    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
